// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the 1x3 router: datapath width, per-port buffer depth,
// header field positions and the destination address encoding.
// Header byte layout: [LEN_MSB:LEN_LSB] payload length, [ADDR_MSB:ADDR_LSB]
// destination address (code 3 is not a valid destination).
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int ROUTER_WIDTH = 8;
    localparam int FIFO_DEPTH   = 16;

    // Header field positions
    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 1;
    localparam int LEN_LSB  = 2;
    localparam int LEN_MSB  = 7;

    // Packet counter holds payload length + 1 (parity), so one bit wider
    // than the length field.
    localparam int PKT_CNT_W = LEN_MSB - LEN_LSB + 2;

    typedef enum logic [1:0] {
        DEST_0       = 2'd0,
        DEST_1       = 2'd1,
        DEST_2       = 2'd2,
        DEST_INVALID = 2'd3
    } dest_e;

    // Number of bytes still to deliver after a header: payload plus parity.
    function automatic logic [PKT_CNT_W-1:0] hdr_remaining(input logic [LEN_MSB:0] hdr);
        return {1'b0, hdr[LEN_MSB:LEN_LSB]} + PKT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/router_fifo.sv
// -----------------------------------------------------------------------------
// router_fifo
// Per-destination output buffer of the 1x3 router. Stores {header flag, byte}
// pairs from the register stage and delivers them to the destination with a
// one-cycle registered read. A packet counter tracks the remaining bytes of the
// packet being read so data_out returns to zero once the parity byte is out.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous active-high reset, clears all state
//   soft_reset  synchronous flush, priority over reads and writes
//   write_enb   write request (dropped while full)
//   read_enb    read request (ignored while empty)
//   lfd_state   marks the byte being written as a packet header
//   data_in     byte from the register stage
//   data_out    registered read data
//   full        DEPTH entries held
//   empty       no entries held
// -----------------------------------------------------------------------------
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = ROUTER_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    // Entry: MSB is the header flag, low WIDTH bits are the byte.
    logic [WIDTH:0] mem [DEPTH];

    logic [AW:0]            wr_ptr_reg, wr_ptr_next;
    logic [AW:0]            rd_ptr_reg, rd_ptr_next;
    logic [PKT_CNT_W-1:0]   pkt_cnt_reg, pkt_cnt_next;
    logic [WIDTH-1:0]       data_out_reg, data_out_next;

    logic                   wr_accept;
    logic                   rd_accept;
    logic [WIDTH:0]         rd_entry;

    // Extra pointer MSB distinguishes full from empty when addresses match.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

    assign wr_accept = write_enb && !full;
    assign rd_accept = read_enb && !empty;
    assign rd_entry  = mem[rd_ptr_reg[AW-1:0]];
    assign data_out  = data_out_reg;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        pkt_cnt_next  = pkt_cnt_reg;
        data_out_next = data_out_reg;

        if (soft_reset) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            pkt_cnt_next  = '0;
            data_out_next = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end

            if (rd_accept) begin
                rd_ptr_next   = rd_ptr_reg + 1'b1;
                data_out_next = rd_entry[WIDTH-1:0];
                // A header always reloads the count, even mid-packet, so a
                // malformed stream resynchronises on the next header.
                if (rd_entry[WIDTH]) begin
                    pkt_cnt_next = hdr_remaining(rd_entry[LEN_MSB:0]);
                end else if (pkt_cnt_reg != '0) begin
                    pkt_cnt_next = pkt_cnt_reg - 1'b1;
                end
            end else if (pkt_cnt_reg == '0) begin
                // Between packets the output idles at zero; mid-packet it holds.
                data_out_next = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            pkt_cnt_reg  <= '0;
            data_out_reg <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            pkt_cnt_reg  <= pkt_cnt_next;
            data_out_reg <= data_out_next;
        end
    end

    // Storage has no reset; stale contents are never visible because the
    // pointers gate every read.
    always_ff @(posedge clock) begin
        if (wr_accept && !soft_reset) begin
            mem[wr_ptr_reg[AW-1:0]] <= {lfd_state, data_in};
        end
    end

endmodule
